// File: rtl/alu_muldiv.sv
// Multi-cycle EX-stage ALU: single-cycle base ops plus iterative RV32M-style
// multiply (shift-add) and divide/remainder (restoring) behind start/done.
module alu_muldiv #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flush,
  input  logic [CTRL_W-1:0] Control_Line,
  input  logic [XLEN-1:0]   SrcA,
  input  logic [XLEN-1:0]   SrcB,
  output logic              busy,
  output logic              done,
  output logic              zero,
  output logic [XLEN-1:0]   ALU_result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_SLT   = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_SLTU  = 4'b0110;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULH  = 4'b1001;
  localparam logic [3:0] OP_MULHU = 4'b1010;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REM   = 4'b1101;
  localparam logic [3:0] OP_REMU  = 4'b1110;

  logic [1:0]      state;
  logic [3:0]      op;
  logic [3:0]      op_in;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] opnd;
  logic [XLEN-1:0] res_pend;
  logic [XLEN-1:0] result_q;
  logic            neg_q;
  logic            neg_r;
  logic [CW-1:0]   cnt;
  logic            accept;

  // acceptance-time decode
  logic            in_mul;
  logic            in_div;
  logic            in_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic            use_iter;
  logic [XLEN-1:0] quick_res;

  // iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi_n;
  logic [XLEN-1:0]   mul_lo_n;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;
  logic              ge;
  logic [XLEN-1:0]   rem_n;
  logic [XLEN-1:0]   quo_n;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   iter_res;

  assign op_in  = Control_Line[3:0];
  assign accept = start & (state == S_IDLE) & ~flush;

  always_comb begin
    in_mul    = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_MULHU);
    in_div    = (op_in == OP_DIV) || (op_in == OP_DIVU) ||
                (op_in == OP_REM) || (op_in == OP_REMU);
    in_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    a_neg     = SrcA[XLEN-1] & in_signed;
    b_neg     = SrcB[XLEN-1] & in_signed;
    a_mag     = a_neg ? (~SrcA + 1'b1) : SrcA;
    b_mag     = b_neg ? (~SrcB + 1'b1) : SrcB;
    div_zero  = (SrcB == '0);
    div_ovf   = in_signed & in_div & (SrcA == MIN_INT) & (SrcB == '1);
    use_iter  = in_mul | (in_div & ~div_zero & ~div_ovf);
  end

  always_comb begin
    quick_res = '0;
    case (op_in)
      OP_ADD:  quick_res = SrcA + SrcB;
      OP_SUB:  quick_res = SrcA - SrcB;
      OP_AND:  quick_res = SrcA & SrcB;
      OP_OR:   quick_res = SrcA | SrcB;
      OP_SLT:  quick_res = {{(XLEN-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      OP_XOR:  quick_res = SrcA ^ SrcB;
      OP_SLTU: quick_res = {{(XLEN-1){1'b0}}, SrcA < SrcB};
      default: quick_res = '0;
    endcase
    // divide corner cases never enter the iterative engine
    if (in_div && div_zero)
      quick_res = ((op_in == OP_DIV) || (op_in == OP_DIVU)) ? '1 : SrcA;
    else if (div_ovf)
      quick_res = (op_in == OP_DIV) ? MIN_INT : '0;
  end

  always_comb begin
    // multiply: {hi,lo} holds partial product over the shifting multiplier
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    mul_hi_n = mul_sum[XLEN:1];
    mul_lo_n = {mul_sum[0], lo[XLEN-1:1]};
    prod     = {mul_hi_n, mul_lo_n};
    prod_s   = neg_q ? (~prod + 1'b1) : prod;

    // divide: hi is the partial remainder, lo shifts dividend out / quotient in
    shifted  = {hi, lo[XLEN-1]};
    diff     = shifted - {1'b0, opnd};
    ge       = ~diff[XLEN];
    rem_n    = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_n    = {lo[XLEN-2:0], ge};
    quo_s    = neg_q ? (~quo_n + 1'b1) : quo_n;
    rem_s    = neg_r ? (~rem_n + 1'b1) : rem_n;

    iter_res = '0;
    case (op)
      OP_MUL:            iter_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHU: iter_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:   iter_res = quo_s;
      OP_REM, OP_REMU:   iter_res = rem_s;
      default:           iter_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op       <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      res_pend <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      cnt      <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op    <= op_in;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            cnt   <= CW'(XLEN);
            hi    <= '0;
            if (in_mul) begin
              lo    <= b_mag;
              opnd  <= a_mag;
              state <= S_MUL;
            end else if (use_iter) begin
              lo    <= a_mag;
              opnd  <= b_mag;
              state <= S_DIV;
            end else begin
              res_pend <= quick_res;
              state    <= S_FIN;
            end
          end
        end
        S_MUL, S_DIV: begin
          hi  <= (state == S_MUL) ? mul_hi_n : rem_n;
          lo  <= (state == S_MUL) ? mul_lo_n : quo_n;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            res_pend <= iter_res;
            state    <= S_FIN;
          end
        end
        default: begin
          result_q <= res_pend;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  // result is visible during FIN and committed at its end; flush in FIN hides both
  assign busy       = (state == S_MUL) | (state == S_DIV) | accept;
  assign done       = (state == S_FIN) & ~flush;
  assign ALU_result = done ? res_pend : result_q;
  assign zero       = (ALU_result == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized self-checking bench for alu_muldiv against an arithmetic model.
module tb_alu_muldiv;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [3:0]  ctrl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic        zero;
  logic [31:0] alu_result;

  int tests;
  int fails;
  logic [31:0] last_res;

  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  alu_muldiv #(.XLEN(32), .CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .Control_Line(ctrl), .SrcA(src_a), .SrcB(src_b),
    .busy(busy), .done(done), .zero(zero), .ALU_result(alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, sp;
    logic [63:0] up, t;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    sp = sa * sb;
    r  = '0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd5:  r = a ^ b;
      4'd6:  r = (a < b) ? 32'd1 : 32'd0;
      4'd8:  r = up[31:0];
      4'd9:  begin t = 64'(sp); r = t[63:32]; end
      4'd10: r = up[63:32];
      4'd11: begin
        if (b == 0) r = '1;
        else if (a == MIN_INT && b == '1) r = MIN_INT;
        else begin t = 64'(sa / sb); r = t[31:0]; end
      end
      4'd12: r = (b == 0) ? '1 : a / b;
      4'd13: begin
        if (b == 0) r = a;
        else if (a == MIN_INT && b == '1) r = '0;
        else begin t = 64'(sa % sb); r = t[31:0]; end
      end
      4'd14: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (op < 4'd8 || op == 4'd15) return 1;
    if (op >= 4'd11 && b == 0) return 1;
    if ((op == 4'd11 || op == 4'd13) && a == MIN_INT && b == '1) return 1;
    return 33;
  endfunction

  // issue one op, watch it to completion, compare latency/busy/result/zero
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int lat, dcyc, bcyc;
    logic [31:0] got;
    logic        gz;
    exp  = model(op, a, b);
    lat  = latency(op, a, b);
    dcyc = -1;
    bcyc = 0;
    got  = '0;
    gz   = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; ctrl = op; src_a = a; src_b = b;
    for (int c = 0; c <= lat + 3; c++) begin
      @(negedge clk);
      if (busy) bcyc++;
      if (done) begin dcyc = c; got = alu_result; gz = zero; break; end
      @(posedge clk); #1;
      start = 1'b0; ctrl = 4'($urandom); src_a = $urandom; src_b = $urandom;
    end
    start = 1'b0;
    tests++;
    if (dcyc !== lat) begin
      fails++;
      $display("FAIL latency op=%0d a=%h b=%h: done at cycle %0d, expected %0d", op, a, b, dcyc, lat);
    end
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL result op=%0d a=%h b=%h: got %h, expected %h", op, a, b, got, exp);
    end
    tests++;
    if (gz !== (exp == 0)) begin
      fails++;
      $display("FAIL zero op=%0d: got %b, expected %b", op, gz, exp == 0);
    end
    tests++;
    if (bcyc !== lat) begin
      fails++;
      $display("FAIL busy_cycles op=%0d: got %0d, expected %0d", op, bcyc, lat);
    end
    last_res = exp;
  endtask

  task automatic test_reset();
    tests++;
    if ({busy, done, zero, alu_result} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b zero=%b res=%h, expected 0 0 1 0",
               busy, done, zero, alu_result);
    end
  endtask

  task automatic test_alu();
    run_op(4'd0, 32'd5, 32'd7);
    run_op(4'd1, 32'd7, 32'd7);
    run_op(4'd7, 32'd3, 32'd4);
    run_op(4'd15, 32'd3, 32'd4);
    run_op(4'd4, 32'hFFFF_FFFF, 32'd1);
    run_op(4'd6, 32'hFFFF_FFFF, 32'd1);
    for (int i = 0; i < 12; i++)
      run_op(4'($urandom_range(0, 7)), $urandom, $urandom);
  endtask

  task automatic test_mul();
    run_op(4'd9, 32'h8000_0000, 32'h8000_0000);
    run_op(4'd8, 32'hFFFF_FFFF, 32'h0000_0003);
    run_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(4'd9, 32'hFFFF_FFFF, 32'd5);
    for (int i = 0; i < 6; i++)
      run_op(4'($urandom_range(8, 10)), $urandom, $urandom);
  endtask

  task automatic test_div();
    logic [31:0] b;
    run_op(4'd11, 32'hFFFF_FFF9, 32'd2);
    run_op(4'd13, 32'hFFFF_FFF9, 32'd2);
    run_op(4'd12, 32'd100, 32'd7);
    run_op(4'd14, 32'd100, 32'd7);
    run_op(4'd11, MIN_INT, 32'd1);
    for (int i = 0; i < 8; i++) begin
      b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 1000));
      if ($urandom_range(0, 1) == 1) b = -b;
      if (b == 0) b = 32'd3;
      run_op(4'($urandom_range(11, 14)), $urandom, b);
    end
  endtask

  task automatic test_special();
    run_op(4'd12, 32'd10, 32'd0);
    run_op(4'd13, 32'd10, 32'd0);
    run_op(4'd11, MIN_INT, 32'hFFFF_FFFF);
    run_op(4'd13, MIN_INT, 32'hFFFF_FFFF);
    run_op(4'd11, $urandom, 32'd0);
    run_op(4'd14, $urandom, 32'd0);
  endtask

  task automatic test_start_while_busy();
    int dcyc, extra;
    logic [31:0] got;
    dcyc = -1; extra = 0; got = '0;
    @(posedge clk); #1;
    start = 1'b1; ctrl = 4'd11; src_a = 32'hFFFF_FFF9; src_b = 32'd2;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) begin dcyc = c; got = alu_result; break; end
      @(posedge clk); #1;
      start = (c + 1 == 5);
      ctrl = 4'd0; src_a = 32'd1; src_b = 32'd1;
    end
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    tests++;
    if (dcyc !== 33 || got !== 32'hFFFF_FFFD) begin
      fails++;
      $display("FAIL start_while_busy: done cycle %0d res %h, expected 33 fffffffd", dcyc, got);
    end
    tests++;
    if (extra !== 0) begin
      fails++;
      $display("FAIL start_while_busy_side_effect: %0d stray busy/done cycles, expected 0", extra);
    end
    last_res = 32'hFFFF_FFFD;
  endtask

  task automatic test_flush();
    int ndone;
    ndone = 0;
    @(posedge clk); #1;
    start = 1'b1; ctrl = 4'd8; src_a = 32'd3; src_b = 32'd4;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) ndone++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    if (done) ndone++;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || alu_result !== last_res) begin
      fails++;
      $display("FAIL flush_cycle11: busy=%b done=%b res=%h, expected 0 0 %h",
               busy, done, alu_result, last_res);
    end
    tests++;
    if (ndone !== 0) begin
      fails++;
      $display("FAIL flush_no_done: %0d done pulses, expected 0", ndone);
    end
    start = 1'b1; ctrl = 4'd0; src_a = 32'd20; src_b = 32'd22;
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL flush_then_accept: busy=%b, expected 1", busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || alu_result !== 32'd42) begin
      fails++;
      $display("FAIL flush_then_add: done=%b res=%h, expected 1 0000002a", done, alu_result);
    end
    last_res = 32'd42;
  endtask

  task automatic test_flush_fin();
    @(posedge clk); #1;
    start = 1'b1; ctrl = 4'd0; src_a = 32'd1; src_b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b1;
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || alu_result !== last_res) begin
      fails++;
      $display("FAIL flush_in_fin: done=%b busy=%b res=%h, expected 0 0 %h",
               done, busy, alu_result, last_res);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || alu_result !== last_res) begin
      fails++;
      $display("FAIL flush_in_fin_after: done=%b res=%h, expected 0 %h", done, alu_result, last_res);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    pat = '0;
    @(posedge clk); #1;
    start = 1'b1; ctrl = 4'd0; src_a = 32'd2; src_b = 32'd3;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      pat[c] = done;
      @(posedge clk); #1;
    end
    start = 1'b0;
    tests++;
    if (pat !== 4'b1010) begin
      fails++;
      $display("FAIL back_to_back: done pattern %b (cycles 3..0), expected 1010", pat);
    end
    last_res = 32'd5;
  endtask

  task automatic test_reset_mid();
    int ndone;
    ndone = 0;
    @(posedge clk); #1;
    start = 1'b1; ctrl = 4'd12; src_a = 32'd1000; src_b = 32'd7;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, zero, alu_result} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
      fails++;
      $display("FAIL async_reset: busy=%b done=%b zero=%b res=%h, expected 0 0 1 0",
               busy, done, zero, alu_result);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    tests++;
    if (ndone !== 0) begin
      fails++;
      $display("FAIL reset_no_done: %0d busy/done cycles after release, expected 0", ndone);
    end
    last_res = '0;
    run_op(4'd12, 32'd1000, 32'd7);
  endtask

  initial begin
    tests = 0; fails = 0; last_res = '0;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    ctrl = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_alu();
    test_mul();
    test_div();
    test_special();
    test_start_while_busy();
    test_flush();
    test_flush_fin();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Parametrised, multi-cycle successor to the single-cycle integer ALU. It executes the base ALU ops in one cycle and adds iterative RV32M-style multiply, divide and remainder through a start/done handshake. It sits in the EX stage. The pipeline stalls on `busy` and captures the result on `done`.

Parameters:
- XLEN, 32, operand/result width (>=8, even).
- CTRL_W, 4, width of Control_Line.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, issue request; accepted only in IDLE.
- flush, input, 1, synchronous abort of the in-flight operation.
- Control_Line, input, CTRL_W, op select; sampled only on an accepted start.
- SrcA, input, XLEN, operand A / dividend; sampled only on an accepted start.
- SrcB, input, XLEN, operand B / divisor; sampled only on an accepted start.
- busy, output, 1, high while an accepted operation is in flight (cycles 0..done-1 after acceptance).
- done, output, 1, one-cycle pulse; ALU_result is valid this cycle.
- zero, output, 1, ALU_result == 0.
- ALU_result, output, XLEN, result register; holds until the next done.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, busy=0, done=0, ALU_result=0, zero=1.
  - All internal registers cleared.
  - Applies immediately, including mid-operation; the interrupted op is lost and no done is produced.
- Op encodings:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLT (signed), 0101 XOR, 0110 SLTU, 0111 reserved (result 0).
  - 1000 MUL (low XLEN), 1001 MULH (s*s high), 1010 MULHU (u*u high), 1011 DIV, 1100 DIVU, 1101 REM, 1110 REMU, 1111 reserved (result 0).
- Arithmetic is modulo 2^XLEN. SLT/SLTU results are 0 or 1, zero-extended.
- States: IDLE, MUL, DIV, FIN.
- Accepted start = start & IDLE & ~flush. This is cycle 0: operands and op are latched and busy rises.
- Single-cycle path (ops 0xxx, reserved ops, and special-case divides):
  - IDLE -> FIN.
  - done=1 and ALU_result valid in cycle 1 (latency 1).
- MUL ops:
  - IDLE -> MUL.
  - Operands are converted to magnitudes per signedness, then shift-add runs one bit per cycle for XLEN cycles over a 2*XLEN accumulator.
  - The product sign is applied on the last iteration.
  - MUL -> FIN; done in cycle XLEN+1.
- DIV/REM ops:
  - IDLE -> DIV.
  - Restoring division, one quotient bit per cycle for XLEN cycles, on magnitudes.
  - Signs applied on the last iteration: quotient negative iff operand signs differ; remainder takes the sign of the dividend.
  - DIV -> FIN; done in cycle XLEN+1.
- Special-case divides, detected at acceptance, latency 1:
  - Divisor 0: DIV/DIVU quotient = all ones; REM/REMU = SrcA.
  - Signed overflow (SrcA = MIN_INT, SrcB = -1): DIV = MIN_INT; REM = 0.
- FIN: done=1, busy=0, ALU_result/zero updated that cycle, then -> IDLE. No back-to-back acceptance in FIN.
- Accepting new work:
  - start is not accepted in FIN.
  - The next start is accepted in the first IDLE cycle after FIN.
  - start while busy is ignored, with no side effects.
- flush (synchronous, highest priority after reset):
  - Any state -> IDLE next cycle; busy=0 next cycle; no done.
  - ALU_result/zero keep their previous values.
  - flush in the same cycle as start blocks acceptance.
  - flush coinciding with FIN suppresses that done; ALU_result is not updated.
- Outputs:
  - zero is derived from the ALU_result register, so it only changes when done fires.
  - busy and done are never high together.

Test Plan:
- ADD 5+7, then SUB 7-7 -> done at cycle 1 each; ALU_result 12, zero 0; then ALU_result 0, zero 1; busy high exactly 1 cycle each.
- MULH 0x80000000*0x80000000, MUL 0xFFFFFFFF*0x00000003, MULHU 0xFFFFFFFF*0xFFFFFFFF -> results 0x40000000, 0xFFFFFFFD, 0xFFFFFFFE; done at cycle 33, busy 33 cycles.
- DIV -7/2 -> 0xFFFFFFFD; REM -7%2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100%7 -> 2; each done at cycle 33.
- DIVU 10/0 -> 0xFFFFFFFF; REM 10%0 -> 10; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0; all done at cycle 1.
- start pulsed at cycle 5 of a DIV -> ignored, original result delivered at cycle 33. flush at cycle 10 of a MUL -> busy 0 at cycle 11, no done, ALU_result unchanged. A new ADD accepted at cycle 11 -> done at cycle 12.
- rst_n low at cycle 15 of a DIV -> busy, done, ALU_result 0 and zero 1 immediately (asynchronously, before the next clock edge); no done after release; a next op after release completes normally.
